// File: rtl/alu_arbiter.sv
// Two-requester arbiter around a shared 64-bit ALU with valid/ready handshakes.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             owner_q;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_res;
  logic             pick1;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             rsp_hs;
  logic             idle;

`ifdef ALU_ARB_RR_EN
  logic             last_q;

  // Tie goes to the requester that was not granted last.
  always_comb begin
    pick1 = req1_valid & (~req0_valid | ~last_q);
  end
`else
  // Requester 0 always wins a tie.
  always_comb begin
    pick1 = req1_valid & ~req0_valid;
  end
`endif

  // Grants only in IDLE and never while reset is asserted.
  always_comb begin
    idle   = (state_q == S_IDLE) & ~rst;
    grant1 = idle & pick1;
    grant0 = idle & req0_valid & ~pick1;
    accept = grant0 | grant1;
    op_d   = grant1 ? req1_op : req0_op;
    x_d    = grant1 ? req1_x : req0_x;
    y_d    = grant1 ? req1_y : req0_y;
  end

  // Shared ALU, fed only from the operand registers.
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      4'd0:    alu_res = x_q & y_q;
      4'd1:    alu_res = x_q | y_q;
      4'd2:    alu_res = x_q + y_q;
      4'd6:    alu_res = x_q - y_q;
      default: alu_res = '0;
    endcase
  end

  // Sequencer next state: accept, evaluate, hold result until consumed.
  always_comb begin
    rsp_hs  = owner_q ? rsp1_ready : rsp0_ready;
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand capture on accept, result capture in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= grant1;
        op_q    <= op_d;
        x_q     <= x_d;
        y_q     <= y_d;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  // Remember the last granted requester; starts at 1 so req0 wins first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= grant1;
    end
  end
`endif

  // Handshake and status outputs, all held low while in reset.
  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp0_valid = ~rst & (state_q == S_RESP) & ~owner_q;
    rsp1_valid = ~rst & (state_q == S_RESP) & owner_q;
    rsp0_data  = result_q;
    rsp1_data  = result_q;
    rsp0_zero  = zero_q;
    rsp1_zero  = zero_q;
    busy       = ~rst & (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus
// hand-written tie, backpressure, reset and isolation sequences.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [63:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [63:0] rsp0_data, rsp1_data;
  logic        rsp0_zero, rsp1_zero;
  logic        busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        who;
    logic [3:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] d;
    logic        z;
  } vec_t;

  typedef struct {
    logic        who;
    logic [63:0] d;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_d[2];
  logic        exp_z[2];
  vec_t        vecs[8];

  alu_arbiter #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic who, input logic v, input logic [3:0] op,
                         input logic [63:0] x, input logic [63:0] y);
    if (who) begin
      req1_valid = v; req1_op = op; req1_x = x; req1_y = y;
    end else begin
      req0_valid = v; req0_op = op; req0_x = x; req0_y = y;
    end
  endtask

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp0_valid && rsp1_valid) check("both_rsp_valid", 1, 0);
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_owner", {63'd0, rsp1_valid}, {63'd0, e.who});
          check("rsp_data", rsp1_valid ? rsp1_data : rsp0_data, e.d);
          check("rsp_zero", {63'd0, rsp1_valid ? rsp1_zero : rsp0_zero},
                {63'd0, e.z});
        end
      end
      if (req0_valid && req0_ready) sb.push_back('{1'b0, exp_d[0], exp_z[0]});
      if (req1_valid && req1_ready) sb.push_back('{1'b1, exp_d[1], exp_z[1]});
    end
  end

  // One isolated op: accept at T, EXEC T+1, response T+2, IDLE T+3.
  // Operands are scrambled right after accept to prove isolation.
  task automatic do_op(input vec_t v);
    logic rdy, rv;
    tick;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    exp_d[v.who] = v.d;
    exp_z[v.who] = v.z;
    set_req(v.who, 1'b1, v.op, v.x, v.y);
    @(negedge clk);
    rdy = v.who ? req1_ready : req0_ready;
    check("op_accept", {63'd0, rdy}, 64'd1);
    tick;
    set_req(v.who, 1'b0, 4'($urandom), {$urandom, $urandom},
            {$urandom, $urandom});
    @(negedge clk);
    rv = v.who ? rsp1_valid : rsp0_valid;
    check("op_exec_busy", {63'd0, busy}, 64'd1);
    check("op_exec_novalid", {63'd0, rv}, 64'd0);
    tick;
    @(negedge clk);
    rv = v.who ? rsp1_valid : rsp0_valid;
    check("op_rsp_valid", {63'd0, rv}, 64'd1);
    tick;
    @(negedge clk);
    check("op_idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic       got;
    logic       ok;
    logic       want;
    logic [3:0] k2;

    vecs[0] = '{1'b0, 4'd2, 64'd5, 64'd7, 64'd12, 1'b0};
    vecs[1] = '{1'b1, 4'd6, 64'd3, 64'd3, 64'd0, 1'b1};
    vecs[2] = '{1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
    vecs[3] = '{1'b0, 4'd5, 64'd9, 64'd4, 64'd0, 1'b1};
    vecs[4] = '{1'b1, 4'd0, 64'hF0, 64'h3C, 64'h30, 1'b0};
    vecs[5] = '{1'b0, 4'd1, 64'hF0, 64'h0F, 64'hFF, 1'b0};
    vecs[6] = '{1'b0, 4'd6, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[7] = '{1'b1, 4'd7, 64'd1, 64'd1, 64'd0, 1'b1};

    // Reset: ready must stay low even with a valid request pending.
    rst = 1'b1;
    req0_valid = 1'b1;
    repeat (2) tick;
    @(negedge clk);
    check("rst_ready0", {63'd0, req0_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
    check("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
    tick;
    rst = 1'b0;
    req0_valid = 1'b0;
    @(negedge clk);
    check("rst_data", rsp0_data, 64'd0);
    check("rst_zero", {63'd0, rsp0_zero}, 64'd0);
    check("rst_busy_after", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    // Tie after reset: alternate under round-robin, req0 only otherwise.
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_d[0] = 64'h30; exp_z[0] = 1'b0;
    exp_d[1] = 64'hFF; exp_z[1] = 1'b0;
    set_req(1'b0, 1'b1, 4'd0, 64'hF0, 64'h3C);
    set_req(1'b1, 1'b1, 4'd1, 64'hF0, 64'h0F);
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) ok = 1'b1;
      end
      check("tie_timeout", {63'd0, ok}, 64'd1);
      got = req1_ready;
      k2 = 4'(k);
`ifdef ALU_ARB_RR_EN
      want = k2[0];
`else
      want = 1'b0;
`endif
      check("tie_grant", {63'd0, got}, {63'd0, want});
      tick;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) tick;

    // Backpressure: response held stable, req1 waits until IDLE.
    exp_d[0] = 64'd2; exp_z[0] = 1'b0;
    rsp0_ready = 1'b0;
    set_req(1'b0, 1'b1, 4'd2, 64'd1, 64'd1);
    @(negedge clk);
    check("bp_accept0", {63'd0, req0_ready}, 64'd1);
    tick;
    set_req(1'b0, 1'b0, 4'd2, 64'd77, 64'd88);
    exp_d[1] = 64'd5; exp_z[1] = 1'b0;
    set_req(1'b1, 1'b1, 4'd2, 64'd2, 64'd3);
    @(negedge clk);
    check("bp_exec_ready1", {63'd0, req1_ready}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick;
      @(negedge clk);
      check("bp_hold_valid", {63'd0, rsp0_valid}, 64'd1);
      check("bp_hold_data", rsp0_data, 64'd2);
      check("bp_hold_ready1", {63'd0, req1_ready}, 64'd0);
    end
    tick;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_ready1", {63'd0, req1_ready}, 64'd0);
    tick;
    @(negedge clk);
    check("bp_after_ready1", {63'd0, req1_ready}, 64'd1);
    tick;
    req1_valid = 1'b0;
    repeat (4) tick;

    // Reset while the response is pending drops the transaction.
    exp_d[0] = 64'd8; exp_z[0] = 1'b0;
    rsp0_ready = 1'b0;
    set_req(1'b0, 1'b1, 4'd2, 64'd4, 64'd4);
    @(negedge clk);
    check("rr_accept", {63'd0, req0_ready}, 64'd1);
    tick;
    req0_valid = 1'b0;
    tick;
    @(negedge clk);
    check("rr_resp_valid", {63'd0, rsp0_valid}, 64'd1);
    tick;
    rst = 1'b1;
    @(negedge clk);
    check("rr_valid_in_rst", {63'd0, rsp0_valid}, 64'd0);
    tick;
    rst = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("rr_valid_after", {63'd0, rsp0_valid}, 64'd0);
    check("rr_busy_after", {63'd0, busy}, 64'd0);
    check("rr_data_after", rsp0_data, 64'd0);
    check("rr_zero_after", {63'd0, rsp0_zero}, 64'd0);
    tick;
    exp_d[0] = 64'h30; exp_z[0] = 1'b0;
    exp_d[1] = 64'hFF; exp_z[1] = 1'b0;
    set_req(1'b0, 1'b1, 4'd0, 64'hF0, 64'h3C);
    set_req(1'b1, 1'b1, 4'd1, 64'hF0, 64'h0F);
    @(negedge clk);
    check("rr_tie_req0", {63'd0, req0_ready}, 64'd1);
    check("rr_tie_req1", {63'd0, req1_ready}, 64'd0);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (5) tick;

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 64-bit ALU instance between two requesters (e.g. the execute stage and an address/CSR helper) with valid/ready handshakes on both request and response sides. A three-state sequencer accepts one operation, registers the operands, evaluates the ALU for one cycle, and holds a registered result until the owning requester consumes it. Arbitration between simultaneous requests is round-robin, or fixed-priority when the configuration macro is absent.

## Interface
Parameters:
- WIDTH, 64, operand/result width; must match the ALU instance.

Ports. Reset is synchronous, active-high; one clock.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  4  ALU control: 0 AND, 1 OR, 2 ADD, 6 SUB, others yield result 0.
- req0_x, req0_y  in  WIDTH  operands.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_data  out  WIDTH  result.
- rsp0_zero  out  1  result == 0.
- req1_*, rsp1_*  same as requester 0, for requester 1.
- busy  out  1  high in EXEC and RESP.

## Operation
- States:
  - IDLE: waiting for a request.
  - EXEC: ALU evaluates the registered operands.
  - RESP: result held for the owning requester.
- IDLE:
  - If any reqN_valid is high, select the winner and assert its reqN_ready combinationally in the same cycle. The loser's ready stays 0.
  - On the edge, latch op/x/y into operand registers, record the owner, and go to EXEC.
- EXEC:
  - The ALU is driven only from the operand registers.
  - On the edge, capture the ALU output into result_q and (result == 0) into zero_q, then go to RESP.
- RESP:
  - rspN_valid = 1 for the owner only.
  - Stay in RESP until rspN_ready = 1, then go to IDLE.
  - No request is accepted in RESP.
- rsp0_data and rsp1_data both drive result_q; rsp0_zero and rsp1_zero both drive zero_q. They are meaningful only with the matching valid.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH with no carry or overflow output. Undefined ops give result 0 and zero = 1.
- Round-robin:
  - last_q holds the last granted requester.
  - If both requesters are valid, the one not equal to last_q wins. If only one is valid, it wins.
  - last_q updates only on acceptance.
- A requester may hold valid across the busy period. Its inputs are sampled only in the accept cycle.
- A requester whose response is pending may assert a new request. It is accepted only after the return to IDLE.

## Timing
- Reset values, while rst is high and in the cycle after:
  - state = IDLE, last_q = 1 (requester 0 wins the first tie).
  - result_q = 0, zero_q = 0.
  - All ready and valid outputs 0, busy 0.
  - req*_ready is forced 0 while rst = 1.
- Latency: accept at cycle T, EXEC at T+1, rspN_valid high from T+2.
  - If rspN_ready is already high at T+2, IDLE at T+3, and the next accept is possible at T+3.
  - Peak throughput: one operation per 3 cycles.
- Response backpressure: rspN_valid, rspN_data and rspN_zero stay stable until the handshake completes.
- Reset mid-operation, in EXEC or RESP: the transaction is dropped, no response is produced, and the next cycle is IDLE.
- A simultaneous rsp handshake and new request in the RESP cycle does not accept the request. It is accepted on the following IDLE cycle.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration as above.
- ALU_ARB_RR_EN undefined:
  - Fixed priority: requester 0 always wins a tie.
  - last_q is not implemented.
  - Requester 1 can starve under continuous requester 0 traffic.

## Test plan
- Single op, req0 ADD x=5 y=7, rsp0_ready held 1:
  - req0_ready pulses at T.
  - rsp0_valid at T+2 with data 12, zero 0.
  - busy high T+1..T+2.
- Wrap and zero:
  - req1 SUB x=3 y=3 -> data 0, zero 1.
  - req1 ADD x=0xFFFF_FFFF_FFFF_FFFF y=1 -> data 0, zero 1.
  - req0 op=5 -> data 0, zero 1.
- Tie after reset, both valid with req0 AND 0xF0/0x3C and req1 OR 0xF0/0x0F:
  - With RR, grants are req0 (data 0x30), then req1 (data 0xFF), alternating over 4 ops.
  - Without the macro, req0 wins all 4.
- Backpressure, req0 ADD 1+1 with rsp0_ready low for 5 cycles:
  - rsp0_valid and data 2 hold stable.
  - req1_valid stays unaccepted until 1 cycle after the rsp0 handshake.
- Reset in RESP:
  - rst for 1 cycle -> rsp0_valid drops, result 0, state IDLE.
  - The pending requester gets no response.
  - The next tie goes to req0.
- Operand isolation:
  - Change req0_x/y after the accept cycle.
  - The result reflects the values sampled at accept.
